// File: rtl/mode_toggle_controller_pkg.sv
// Shared types and mode codes for the mode toggle controller.
// The mode codes must match the encoding used by the mode FSM.
package mode_toggle_controller_pkg;

    localparam int MTC_MODE_WIDTH = 3;

    localparam logic [MTC_MODE_WIDTH-1:0] STAND_MODE  = 3'd0;
    localparam logic [MTC_MODE_WIDTH-1:0] FIRST_MODE  = 3'd1;
    localparam logic [MTC_MODE_WIDTH-1:0] SECOND_MODE = 3'd2;
    localparam logic [MTC_MODE_WIDTH-1:0] THIRD_MODE  = 3'd3;

    typedef enum logic [2:0] {
        MTC_IDLE     = 3'd0,
        MTC_PRESSED  = 3'd1,
        MTC_HELD     = 3'd2,
        MTC_LOCKOUT  = 3'd3,
        MTC_WAIT_REL = 3'd4
    } mtc_state_e;

    function automatic logic mtc_is_busy(input mtc_state_e state);
        return state != MTC_IDLE;
    endfunction

endpackage

// File: rtl/mode_toggle_controller_cycle_timer.sv
// Saturating up-counter with synchronous clear and a programmable terminal value.
// done is high while the count sits at the terminal value.
module cycle_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             clr,
    input  logic             en,
    input  logic [WIDTH-1:0] terminal,
    output logic [WIDTH-1:0] count,
    output logic             done
);

    logic [WIDTH-1:0] r_count;

    // Stops at the terminal value so a long hold can never wrap around.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (en && (r_count != terminal)) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    assign count = r_count;
    assign done  = (r_count == terminal);

endmodule

// File: rtl/mode_toggle_controller.sv
// Turns the debounced button level into one-cycle short/long press events,
// one-hot by the mode that was active when the press started.
module mode_toggle_controller
    import mode_toggle_controller_pkg::*;
#(
    parameter int                   MODE_WIDTH     = MTC_MODE_WIDTH,
    parameter int                   NUM_MODES      = 4,
    parameter logic [NUM_MODES-1:0] MODE_EN_MASK   = {NUM_MODES{1'b1}},
    parameter int                   HOLD_CYCLES    = 300_000_000,
    parameter int                   LOCKOUT_CYCLES = 20_000_000
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  toggle_signal,
    input  logic [MODE_WIDTH-1:0] current_mode,
    output logic [NUM_MODES-1:0]  short_toggle,
    output logic [NUM_MODES-1:0]  long_toggle,
    output logic                  busy
);

    localparam int HOLD_W     = $clog2(HOLD_CYCLES);
    localparam int LOCK_W     = $clog2(LOCKOUT_CYCLES + 1);
    localparam int MODE_SPACE = 2 ** MODE_WIDTH;

    localparam logic [HOLD_W-1:0] HOLD_TERM = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [LOCK_W-1:0] LOCK_TERM = LOCK_W'(LOCKOUT_CYCLES - 1);

    // Zero-extending the mask over the whole code space also rejects codes >= NUM_MODES.
    localparam logic [MODE_SPACE-1:0] MODE_ACCEPT = MODE_SPACE'(MODE_EN_MASK);

    mtc_state_e              r_state;
    mtc_state_e              w_state_next;
    logic                    r_prev;
    logic [MODE_WIDTH-1:0]   r_latched_mode;
    logic [NUM_MODES-1:0]    r_short;
    logic [NUM_MODES-1:0]    r_long;

    logic                    w_rise;
    logic                    w_mode_ok;
    logic                    w_latch_en;
    logic [NUM_MODES-1:0]    w_latched_onehot;
    logic [NUM_MODES-1:0]    w_short_next;
    logic [NUM_MODES-1:0]    w_long_next;

    logic                    w_hold_clr;
    logic                    w_hold_en;
    logic                    w_hold_done;
    logic [HOLD_W-1:0]       w_hold_count;
    logic                    w_lock_clr;
    logic                    w_lock_en;
    logic                    w_lock_done;
    logic [LOCK_W-1:0]       w_lock_count;
    logic                    w_unused_counts;

    assign w_rise           = toggle_signal & ~r_prev;
    assign w_mode_ok        = MODE_ACCEPT[current_mode];
    assign w_latched_onehot = NUM_MODES'(1) << r_latched_mode;

    assign w_hold_clr = (r_state != MTC_PRESSED);
    assign w_hold_en  = (r_state == MTC_PRESSED) & toggle_signal;
    assign w_lock_clr = (r_state != MTC_LOCKOUT);
    assign w_lock_en  = (r_state == MTC_LOCKOUT);

    cycle_timer #(
        .WIDTH(HOLD_W)
    ) u_hold_timer (
        .clk      (clk),
        .rstn     (rstn),
        .clr      (w_hold_clr),
        .en       (w_hold_en),
        .terminal (HOLD_TERM),
        .count    (w_hold_count),
        .done     (w_hold_done)
    );

    cycle_timer #(
        .WIDTH(LOCK_W)
    ) u_lock_timer (
        .clk      (clk),
        .rstn     (rstn),
        .clr      (w_lock_clr),
        .en       (w_lock_en),
        .terminal (LOCK_TERM),
        .count    (w_lock_count),
        .done     (w_lock_done)
    );

    assign w_unused_counts = ^{w_hold_count, w_lock_count};

    // A mode change mid-press wins over both release and hold expiry.
    always_comb begin
        w_state_next = r_state;
        w_short_next = '0;
        w_long_next  = '0;
        w_latch_en   = 1'b0;
        case (r_state)
            MTC_IDLE: begin
                if (w_rise && w_mode_ok) begin
                    w_latch_en   = 1'b1;
                    w_state_next = MTC_PRESSED;
                end
            end
            MTC_PRESSED: begin
                if (current_mode != r_latched_mode) begin
                    w_state_next = MTC_WAIT_REL;
                end else if (!toggle_signal) begin
                    w_short_next = w_latched_onehot;
                    w_state_next = MTC_LOCKOUT;
                end else if (w_hold_done) begin
                    w_long_next  = w_latched_onehot;
                    w_state_next = MTC_HELD;
                end
            end
            MTC_HELD: begin
                if (!toggle_signal) begin
                    w_state_next = MTC_LOCKOUT;
                end
            end
            MTC_LOCKOUT: begin
                if (w_lock_done) begin
                    w_state_next = MTC_IDLE;
                end
            end
            MTC_WAIT_REL: begin
                if (!toggle_signal) begin
                    w_state_next = MTC_IDLE;
                end
            end
            default: begin
                w_state_next = MTC_IDLE;
            end
        endcase
    end

    // The edge register resets high so a button held through reset is not a press.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state        <= MTC_IDLE;
            r_prev         <= 1'b1;
            r_latched_mode <= '0;
            r_short        <= '0;
            r_long         <= '0;
        end else begin
            r_state <= w_state_next;
            r_prev  <= toggle_signal;
            r_short <= w_short_next;
            r_long  <= w_long_next;
            if (w_latch_en) begin
                r_latched_mode <= current_mode;
            end
        end
    end

    assign short_toggle = r_short;
    assign long_toggle  = r_long;
    assign busy         = mtc_is_busy(r_state);

endmodule

// File: tb/tb_mode_toggle_controller.sv
// Bench for mode_toggle_controller: directed scenarios plus a random run,
// all checked against a time-based behavioural model of press handling.
module tb_mode_toggle_controller;

    localparam int             HOLD = 8;
    localparam int             LOCK = 4;
    localparam int             NM   = 4;
    localparam logic [NM-1:0]  MASK = 4'b1011;

    localparam int P_IDLE  = 0;
    localparam int P_PRESS = 1;
    localparam int P_HELD  = 2;
    localparam int P_LOCK  = 3;
    localparam int P_WAIT  = 4;

    logic          clk;
    logic          rstn;
    logic          toggle_signal;
    logic [2:0]    current_mode;
    logic [NM-1:0] short_toggle;
    logic [NM-1:0] long_toggle;
    logic          busy;

    int            n_checks;
    int            n_pass;
    int            cyc;

    int            m_phase;
    bit            m_prev;
    int            m_mode;
    int            m_rise_cyc;
    int            m_lock_start;
    logic [NM-1:0] exp_short;
    logic [NM-1:0] exp_long;
    logic          exp_busy;

    mode_toggle_controller #(
        .MODE_WIDTH     (3),
        .NUM_MODES      (NM),
        .MODE_EN_MASK   (MASK),
        .HOLD_CYCLES    (HOLD),
        .LOCKOUT_CYCLES (LOCK)
    ) dut (
        .clk           (clk),
        .rstn          (rstn),
        .toggle_signal (toggle_signal),
        .current_mode  (current_mode),
        .short_toggle  (short_toggle),
        .long_toggle   (long_toggle),
        .busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        m_phase   = P_IDLE;
        m_prev    = 1'b1;
        m_mode    = 0;
        exp_short = '0;
        exp_long  = '0;
        exp_busy  = 1'b0;
    endtask

    // Press timing is tracked as absolute cycle numbers: a long press fires
    // HOLD edges after the rise edge, lockout ends LOCK edges after it starts.
    task automatic model_edge(input bit tog, input int mode);
        bit rise;
        rise      = tog && !m_prev;
        m_prev    = tog;
        exp_short = '0;
        exp_long  = '0;
        case (m_phase)
            P_IDLE: begin
                if (rise && mode < NM && MASK[mode[1:0]]) begin
                    m_phase    = P_PRESS;
                    m_mode     = mode;
                    m_rise_cyc = cyc;
                end
            end
            P_PRESS: begin
                if (mode != m_mode) begin
                    m_phase = P_WAIT;
                end else if (!tog) begin
                    exp_short[m_mode] = 1'b1;
                    m_phase           = P_LOCK;
                    m_lock_start      = cyc;
                end else if (cyc - m_rise_cyc == HOLD) begin
                    exp_long[m_mode] = 1'b1;
                    m_phase          = P_HELD;
                end
            end
            P_HELD: begin
                if (!tog) begin
                    m_phase      = P_LOCK;
                    m_lock_start = cyc;
                end
            end
            P_LOCK: begin
                if (cyc - m_lock_start == LOCK) m_phase = P_IDLE;
            end
            default: begin
                if (!tog) m_phase = P_IDLE;
            end
        endcase
        exp_busy = (m_phase != P_IDLE);
    endtask

    task automatic tick(input bit tog, input int mode);
        toggle_signal = tog;
        current_mode  = 3'(mode);
        @(posedge clk);
        cyc++;
        model_edge(tog, mode);
        #1;
    endtask

    task automatic test_reset();
        rstn          = 1'b0;
        toggle_signal = 1'b1;
        current_mode  = 3'd1;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        n_checks += 3;
        if (short_toggle !== 4'b0000) $display("[TB] FAIL reset_short got=%b exp=0000", short_toggle); else n_pass++;
        if (long_toggle !== 4'b0000) $display("[TB] FAIL reset_long got=%b exp=0000", long_toggle); else n_pass++;
        if (busy !== 1'b0) $display("[TB] FAIL reset_busy got=%b exp=0", busy); else n_pass++;
        rstn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick(1'b1, 1);
            n_checks += 3;
            if (short_toggle !== exp_short) $display("[TB] FAIL held_thru_reset_short cyc=%0d got=%b exp=%b", cyc, short_toggle, exp_short); else n_pass++;
            if (long_toggle !== exp_long) $display("[TB] FAIL held_thru_reset_long cyc=%0d got=%b exp=%b", cyc, long_toggle, exp_long); else n_pass++;
            if (busy !== exp_busy) $display("[TB] FAIL held_thru_reset_busy cyc=%0d got=%b exp=%b", cyc, busy, exp_busy); else n_pass++;
        end
    endtask

    task automatic test_short_press();
        bit tog_seq[14] = '{0,0,0,0,0,0,1,1,1,0,0,0,0,0};
        for (int i = 0; i < 14; i++) begin
            tick(tog_seq[i], 3);
            n_checks += 3;
            if (short_toggle !== exp_short) $display("[TB] FAIL short_press_short cyc=%0d got=%b exp=%b", cyc, short_toggle, exp_short); else n_pass++;
            if (long_toggle !== exp_long) $display("[TB] FAIL short_press_long cyc=%0d got=%b exp=%b", cyc, long_toggle, exp_long); else n_pass++;
            if (busy !== exp_busy) $display("[TB] FAIL short_press_busy cyc=%0d got=%b exp=%b", cyc, busy, exp_busy); else n_pass++;
            if (i == 9) begin
                n_checks++;
                if (short_toggle !== 4'b1000) $display("[TB] FAIL short_pulse_value got=%b exp=1000", short_toggle); else n_pass++;
            end
            if (i == 13) begin
                n_checks++;
                if (busy !== 1'b0) $display("[TB] FAIL short_lockout_end got=%b exp=0", busy); else n_pass++;
            end
        end
    endtask

    task automatic test_long_press();
        for (int i = -6; i < 30; i++) begin
            tick(i >= 0 && i < 20, 1);
            n_checks += 3;
            if (short_toggle !== exp_short) $display("[TB] FAIL long_press_short cyc=%0d got=%b exp=%b", cyc, short_toggle, exp_short); else n_pass++;
            if (long_toggle !== exp_long) $display("[TB] FAIL long_press_long cyc=%0d got=%b exp=%b", cyc, long_toggle, exp_long); else n_pass++;
            if (busy !== exp_busy) $display("[TB] FAIL long_press_busy cyc=%0d got=%b exp=%b", cyc, busy, exp_busy); else n_pass++;
            if (i == HOLD) begin
                n_checks++;
                if (long_toggle !== 4'b0010) $display("[TB] FAIL long_pulse_latency got=%b exp=0010", long_toggle); else n_pass++;
            end
        end
    endtask

    task automatic test_lockout_and_disabled();
        bit tog_seq[30] = '{0,0,0,0,0,0, 1,1,0, 0,1,1,1,1,0, 0,1,0, 0,0,0,0,0,0, 1,1,0,0,0,0};
        for (int i = 0; i < 30; i++) begin
            tick(tog_seq[i], (i < 24) ? 0 : 2);
            n_checks += 3;
            if (short_toggle !== exp_short) $display("[TB] FAIL lockout_short cyc=%0d got=%b exp=%b", cyc, short_toggle, exp_short); else n_pass++;
            if (long_toggle !== exp_long) $display("[TB] FAIL lockout_long cyc=%0d got=%b exp=%b", cyc, long_toggle, exp_long); else n_pass++;
            if (busy !== exp_busy) $display("[TB] FAIL lockout_busy cyc=%0d got=%b exp=%b", cyc, busy, exp_busy); else n_pass++;
            if (i == 11) begin
                n_checks++;
                if (short_toggle !== 4'b0000) $display("[TB] FAIL lockout_rise_ignored got=%b exp=0000", short_toggle); else n_pass++;
            end
            if (i == 17) begin
                n_checks++;
                if (short_toggle !== 4'b0001) $display("[TB] FAIL after_lockout_press got=%b exp=0001", short_toggle); else n_pass++;
            end
            if (i == 25) begin
                n_checks++;
                if (busy !== 1'b0) $display("[TB] FAIL disabled_mode_busy got=%b exp=0", busy); else n_pass++;
            end
        end
    endtask

    task automatic test_mode_abort();
        for (int i = -6; i < 12; i++) begin
            tick(i >= 0 && i < 6, (i >= 4) ? 3 : 0);
            n_checks += 3;
            if (short_toggle !== exp_short) $display("[TB] FAIL abort_short cyc=%0d got=%b exp=%b", cyc, short_toggle, exp_short); else n_pass++;
            if (long_toggle !== exp_long) $display("[TB] FAIL abort_long cyc=%0d got=%b exp=%b", cyc, long_toggle, exp_long); else n_pass++;
            if (busy !== exp_busy) $display("[TB] FAIL abort_busy cyc=%0d got=%b exp=%b", cyc, busy, exp_busy); else n_pass++;
            if (i == 6) begin
                n_checks++;
                if (busy !== 1'b0) $display("[TB] FAIL abort_no_lockout got=%b exp=0", busy); else n_pass++;
            end
        end
    endtask

    task automatic test_out_of_range();
        for (int i = 0; i < 16; i++) begin
            tick(i % 4 == 1, (i < 8) ? 5 : 7);
            n_checks += 3;
            if (short_toggle !== exp_short) $display("[TB] FAIL range_short cyc=%0d got=%b exp=%b", cyc, short_toggle, exp_short); else n_pass++;
            if (long_toggle !== exp_long) $display("[TB] FAIL range_long cyc=%0d got=%b exp=%b", cyc, long_toggle, exp_long); else n_pass++;
            if (busy !== exp_busy) $display("[TB] FAIL range_busy cyc=%0d got=%b exp=%b", cyc, busy, exp_busy); else n_pass++;
        end
    endtask

    task automatic test_reset_mid_press();
        for (int i = -6; i < 8; i++) tick(i >= 0, 1);
        n_checks++;
        if (busy !== 1'b1) $display("[TB] FAIL mid_press_busy got=%b exp=1", busy); else n_pass++;
        rstn = 1'b0;
        model_reset();
        #1;
        n_checks += 3;
        if (short_toggle !== 4'b0000) $display("[TB] FAIL midreset_short got=%b exp=0000", short_toggle); else n_pass++;
        if (long_toggle !== 4'b0000) $display("[TB] FAIL midreset_long got=%b exp=0000", long_toggle); else n_pass++;
        if (busy !== 1'b0) $display("[TB] FAIL midreset_busy got=%b exp=0", busy); else n_pass++;
        @(posedge clk);
        #1;
        rstn = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick(1'b1, 1);
            n_checks += 3;
            if (short_toggle !== exp_short) $display("[TB] FAIL post_reset_short cyc=%0d got=%b exp=%b", cyc, short_toggle, exp_short); else n_pass++;
            if (long_toggle !== exp_long) $display("[TB] FAIL post_reset_long cyc=%0d got=%b exp=%b", cyc, long_toggle, exp_long); else n_pass++;
            if (busy !== exp_busy) $display("[TB] FAIL post_reset_busy cyc=%0d got=%b exp=%b", cyc, busy, exp_busy); else n_pass++;
        end
    endtask

    task automatic test_random();
        bit tog  = 1'b0;
        int mode = 0;
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 6) == 0) tog = !tog;
            if ($urandom_range(0, 24) == 0) mode = int'($urandom_range(0, 7));
            tick(tog, mode);
            n_checks += 3;
            if (short_toggle !== exp_short) $display("[TB] FAIL random_short cyc=%0d got=%b exp=%b", cyc, short_toggle, exp_short); else n_pass++;
            if (long_toggle !== exp_long) $display("[TB] FAIL random_long cyc=%0d got=%b exp=%b", cyc, long_toggle, exp_long); else n_pass++;
            if (busy !== exp_busy) $display("[TB] FAIL random_busy cyc=%0d got=%b exp=%b", cyc, busy, exp_busy); else n_pass++;
        end
    endtask

    initial begin
        n_checks      = 0;
        n_pass        = 0;
        cyc           = 0;
        rstn          = 1'b0;
        toggle_signal = 1'b0;
        current_mode  = 3'd0;
        model_reset();
        #2;
        test_reset();
        test_short_press();
        test_long_press();
        test_lockout_and_disabled();
        test_mode_abort();
        test_out_of_range();
        test_reset_mid_press();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
